// File: rtl/uart_burst_fifo.sv
// uart_burst_fifo: full-duplex 8N1 UART with a word-wide CPU bus and a TX word FIFO.
// In normal mode each word carries one byte. In burst mode each word carries DW/8
// bytes, sent LSB first. The mode is stored with every FIFO entry, so changing the
// mode never alters words that are already queued.
module uart_burst_fifo #(
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int DIV_W   = 9,
    parameter int DIV_RST = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d,
    input  logic          wrtx,
    input  logic          wrbaud,
    input  logic          rd,
    input  logic          rxd,
    output logic          txd,
    output logic [DW-1:0] q,
    output logic          dv,
    output logic          ovf,
    output logic          ferr,
    output logic          thre,
    output logic          tend
);

    localparam int NB = DW / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic             mode;
    logic [DIV_W-1:0] div;

    // Configuration register: MODE and bit-time divider
    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= 1'b0;
            div  <= DIV_W'(DIV_RST);
        end else if (wrbaud) begin
            mode <= d[DW-1];
            div  <= d[DIV_W-1:0];
        end
    end

    // ---------------- TX FIFO ----------------
    logic [DW:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        empty, full, push, pop;
    logic [DW:0] head;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push  = wrtx && !full;
    assign thre  = !full;
    assign head  = mem[rptr[AW-1:0]];

    // FIFO pointers; the extra MSB tells full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // FIFO storage; each entry holds the mode in force at push time
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= {mode, d};
    end

    // ---------------- TX FSM ----------------
    state_t           tx_state, tx_state_nxt;
    logic [DIV_W-1:0] tx_cnt, tx_cnt_nxt, tx_div, tx_div_nxt;
    logic [2:0]       tx_bit, tx_bit_nxt;
    logic [CW-1:0]    tx_left, tx_left_nxt;
    logic [DW-1:0]    tx_word, tx_word_nxt;
    logic             load;

    // TX state register
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_left  <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_left  <= tx_left_nxt;
        end
        tx_div  <= tx_div_nxt;
        tx_word <= tx_word_nxt;
    end

    // TX next state; a new word is loaded from IDLE or straight out of the last STOP
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_div_nxt   = tx_div;
        tx_bit_nxt   = tx_bit;
        tx_left_nxt  = tx_left;
        tx_word_nxt  = tx_word;
        load         = 1'b0;
        pop          = 1'b0;
        case (tx_state)
            IDLE: begin
                if (!empty) load = 1'b1;
            end
            START: begin
                if (tx_cnt == '0) begin
                    tx_state_nxt = DATA;
                    tx_cnt_nxt   = tx_div;
                    tx_bit_nxt   = 3'd0;
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_nxt = tx_div;
                    if (tx_bit == 3'd7) tx_state_nxt = STOP;
                    else                tx_bit_nxt   = tx_bit + 3'd1;
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt == '0) begin
                    if (tx_left > CW'(1)) begin
                        tx_state_nxt = START;
                        tx_cnt_nxt   = tx_div;
                        tx_left_nxt  = tx_left - 1'b1;
                        tx_word_nxt  = tx_word >> 8;
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        tx_state_nxt = IDLE;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
            default: tx_state_nxt = IDLE;
        endcase
        if (load) begin
            pop          = 1'b1;
            tx_state_nxt = START;
            tx_cnt_nxt   = div;
            tx_div_nxt   = div;
            tx_word_nxt  = head[DW-1:0];
            tx_left_nxt  = head[DW] ? CW'(NB) : CW'(1);
        end
    end

    // Registered serial output and end-of-transmission flag
    always_ff @(posedge clk) begin
        if (rst) begin
            txd  <= 1'b1;
            tend <= 1'b1;
        end else begin
            case (tx_state)
                START:   txd <= 1'b0;
                DATA:    txd <= tx_word[tx_bit];
                default: txd <= 1'b1;
            endcase
            tend <= empty && !push && (tx_state == IDLE);
        end
    end

    // ---------------- RX FSM ----------------
    state_t           rx_state, rx_state_nxt;
    logic [1:0]       rx_sync;
    logic [DIV_W-1:0] rx_cnt, rx_cnt_nxt, rx_div, rx_div_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_byte, rx_byte_nxt;
    logic [DIV_W:0]   half;
    logic             frame_ok, frame_bad;

    assign half = ({1'b0, div} + 1'b1) >> 1;

    // RX synchroniser and state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], rxd};
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
        end
        rx_div  <= rx_div_nxt;
        rx_byte <= rx_byte_nxt;
    end

    // RX next state; start bit re-checked at mid-bit, data sampled every bit time
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_div_nxt   = rx_div;
        rx_bit_nxt   = rx_bit;
        rx_byte_nxt  = rx_byte;
        frame_ok     = 1'b0;
        frame_bad    = 1'b0;
        case (rx_state)
            IDLE: begin
                if (!rx_sync[1]) begin
                    rx_state_nxt = START;
                    rx_div_nxt   = div;
                    rx_cnt_nxt   = DIV_W'(half - 1'b1);
                end
            end
            START: begin
                if (rx_cnt == '0) begin
                    if (rx_sync[1]) begin
                        rx_state_nxt = IDLE;
                    end else begin
                        rx_state_nxt = DATA;
                        rx_cnt_nxt   = rx_div;
                        rx_bit_nxt   = 3'd0;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
            DATA: begin
                if (rx_cnt == '0) begin
                    rx_byte_nxt = {rx_sync[1], rx_byte[7:1]};
                    rx_cnt_nxt  = rx_div;
                    if (rx_bit == 3'd7) rx_state_nxt = STOP;
                    else                rx_bit_nxt   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
            STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_nxt = IDLE;
                    frame_ok     = rx_sync[1];
                    frame_bad    = !rx_sync[1];
                end else begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end
            end
            default: rx_state_nxt = IDLE;
        endcase
    end

    // ---------------- RX word assembly ----------------
    logic [CW-1:0] rx_k;
    logic [DW-1:0] acc, rx_word;
    logic          complete;

    // Candidate word with the freshly received byte merged in
    always_comb begin
        rx_word = '0;
        if (mode) begin
            rx_word              = acc;
            rx_word[8*rx_k +: 8] = rx_byte;
        end else begin
            rx_word[7:0] = rx_byte;
        end
    end

    assign complete = frame_ok && (!mode || rx_k == CW'(NB - 1));

    // Partial burst word accumulator
    always_ff @(posedge clk) begin
        if (frame_ok && mode) acc <= rx_word;
    end

    // Byte position, received word and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_k <= '0;
            q    <= '0;
            dv   <= 1'b0;
            ovf  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (frame_ok && mode) rx_k <= complete ? '0 : rx_k + 1'b1;
            if (wrbaud)           rx_k <= '0;
            if (complete) begin
                q  <= rx_word;
                dv <= 1'b1;
                if (dv && !rd) ovf <= 1'b1;
            end else if (rd) begin
                dv  <= 1'b0;
                ovf <= 1'b0;
            end
            if (frame_bad) ferr <= 1'b1;
            else if (rd)   ferr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_burst_fifo.sv
// Directed testbench for uart_burst_fifo: loopback transfers, burst mode, mode
// switch mid-frame, FIFO overflow, overrun, framing error and reset mid-frame.
module tb_uart_burst_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d = '0;
    logic        wrtx = 1'b0, wrbaud = 1'b0, rd = 1'b0;
    logic        rxd_drv = 1'b1, loop = 1'b1;
    logic        rxd;
    logic        txd;
    logic [31:0] q;
    logic        dv, ovf, ferr, thre, tend;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int dv_rises = 0;
    logic dv_q = 1'b0;

    logic [8:0] mon_q[$];
    int         mon_t[$];

    assign rxd = loop ? txd : rxd_drv;

    uart_burst_fifo #(.DW(32), .DEPTH(4), .DIV_W(9), .DIV_RST(7)) dut (
        .clk(clk), .rst(rst), .d(d), .wrtx(wrtx), .wrbaud(wrbaud), .rd(rd),
        .rxd(rxd), .txd(txd), .q(q), .dv(dv), .ovf(ovf), .ferr(ferr),
        .thre(thre), .tend(tend)
    );

    always #5 clk = ~clk;

    // Cycle counter and dv rising-edge counter
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        dv_q <= dv;
        if (dv && !dv_q) dv_rises <= dv_rises + 1;
    end

    // Serial line monitor: decodes txd frames (8 clk per bit) into {stop, byte}
    initial begin
        logic [7:0] b;
        int         st;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                st = cyc;
                repeat (3) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge clk);
                    b[i] = txd;
                end
                repeat (8) @(negedge clk);
                mon_q.push_back({txd, b});
                mon_t.push_back(st);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic cfg(input logic [31:0] v);
        d = v; wrbaud = 1'b1;
        @(negedge clk);
        wrbaud = 1'b0;
    endtask

    task automatic write_tx(input logic [31:0] v);
        d = v; wrtx = 1'b1;
        @(negedge clk);
        wrtx = 1'b0;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic wait_tend(input int from, input int budget, output int took);
        int k = 0;
        while (tend !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        took = cyc - from;
        if (tend !== 1'b1) chk("tend_timeout", 0, 1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        rxd_drv = 1'b0; tick(8);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i]; tick(8);
        end
        rxd_drv = stopb; tick(8);
        rxd_drv = 1'b1;
    endtask

    initial begin
        int t0, took, r0;
        logic [7:0] exp_b;

        tick(3);
        rst = 1'b0;
        tick(1);
        // Reset state
        chk("rst_txd", txd, 1);
        chk("rst_q", q, 0);
        chk("rst_dv", dv, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_thre", thre, 1);
        chk("rst_tend", tend, 1);

        // T1: single byte, normal mode, latency and tend timing
        mon_q.delete(); mon_t.delete();
        cfg(32'h0000_0007);
        write_tx(32'h41);
        t0 = cyc;
        chk("t1_tend_low", tend, 0);
        tick(1);
        chk("t1_txd_n1", txd, 1);
        tick(1);
        chk("t1_txd_n2", txd, 0);
        wait_tend(t0, 300, took);
        chk("t1_tend_cycles", took, 82);
        tick(4);
        chk("t1_frames", mon_q.size(), 1);
        chk("t1_byte", mon_q[0], {1'b1, 8'h41});
        chk("t1_dv", dv, 1);
        chk("t1_q", q, 32'h41);
        pulse_rd();
        chk("t1_dv_rd", dv, 0);

        // T2: burst mode, four gapless frames, one completed word
        mon_q.delete(); mon_t.delete();
        cfg(32'h8000_0007);
        r0 = dv_rises;
        write_tx(32'h4443_4241);
        t0 = cyc;
        wait_tend(t0, 600, took);
        chk("t2_tend_cycles", took, 322);
        tick(4);
        chk("t2_frames", mon_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h41 + 8'(i);
            chk($sformatf("t2_byte%0d", i), mon_q[i], {1'b1, exp_b});
        end
        chk("t2_gapless", mon_t[3] - mon_t[0], 240);
        chk("t2_dv_once", dv_rises - r0, 1);
        chk("t2_q", q, 32'h4443_4241);
        pulse_rd();

        // T3: mode switch during an in-flight normal-mode word
        do_reset();
        mon_q.delete(); mon_t.delete();
        cfg(32'h0000_0007);
        write_tx(32'h42);
        t0 = cyc;
        tick(38);
        cfg(32'h8000_0007);
        wait_tend(t0, 600, took);
        chk("t3_tend_cycles", took, 82);
        tick(4);
        chk("t3_frames", mon_q.size(), 1);
        chk("t3_byte", mon_q[0], {1'b1, 8'h42});
        chk("t3_dv_partial", dv, 0);
        mon_q.delete(); mon_t.delete();
        write_tx(32'h4443_4241);
        t0 = cyc;
        wait_tend(t0, 600, took);
        tick(4);
        chk("t3_burst_frames", mon_q.size(), 4);
        chk("t3_burst_last", mon_q[3], {1'b1, 8'h44});
        chk("t3_dv", dv, 1);
        chk("t3_q", q, 32'h4342_4142);

        // T4: six back-to-back pushes into a four-deep FIFO
        do_reset();
        mon_q.delete(); mon_t.delete();
        cfg(32'h0000_0007);
        for (int i = 1; i <= 6; i++) begin
            d = 32'(i); wrtx = 1'b1;
            @(negedge clk);
            if (i == 4) chk("t4_thre_4th", thre, 1);
            if (i == 5) chk("t4_thre_5th", thre, 0);
        end
        wrtx = 1'b0;
        t0 = cyc;
        wait_tend(t0, 1000, took);
        tick(4);
        chk("t4_frames", mon_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            exp_b = 8'(i + 1);
            chk($sformatf("t4_byte%0d", i), mon_q[i], {1'b1, exp_b});
        end
        chk("t4_thre_end", thre, 1);
        chk("t4_q", q, 32'h05);

        // T5: overrun and rd clearing
        do_reset();
        cfg(32'h0000_0007);
        write_tx(32'h11);
        t0 = cyc;
        write_tx(32'h22);
        wait_tend(t0, 600, took);
        tick(4);
        chk("t5_dv", dv, 1);
        chk("t5_ovf", ovf, 1);
        chk("t5_q", q, 32'h22);
        pulse_rd();
        chk("t5_dv_rd", dv, 0);
        chk("t5_ovf_rd", ovf, 0);

        // T6: framing error on a driven frame, a clean frame, then reset mid-TX
        do_reset();
        loop = 1'b0;
        rxd_drv = 1'b1;
        tick(4);
        send_rx(8'h55, 1'b0);
        tick(8);
        chk("t6_ferr", ferr, 1);
        chk("t6_dv", dv, 0);
        pulse_rd();
        chk("t6_ferr_rd", ferr, 0);
        send_rx(8'h3C, 1'b1);
        tick(8);
        chk("t6_good_dv", dv, 1);
        chk("t6_good_q", q, 32'h3C);
        chk("t6_good_ferr", ferr, 0);
        loop = 1'b1;
        write_tx(32'h41);
        tick(30);
        chk("t6_tend_busy", tend, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_txd", txd, 1);
        chk("t6_rst_tend", tend, 1);
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
